// File: rtl/alu_rs_if.sv
// Dispatch, result-broadcast and ALU-issue signals of the ALU reservation station.
// The dispatcher/CDB side uses master; the reservation station uses slave.
interface alu_rs_if;
    logic        _rs_ready;
    logic [4:0]  _rs_rob_id;
    logic [6:0]  _rs_type;
    logic [3:0]  _rs_op;
    logic        _rs_q1_ready;
    logic        _rs_q2_ready;
    logic [4:0]  _rs_q1;
    logic [4:0]  _rs_q2;
    logic [31:0] _rs_v1;
    logic [31:0] _rs_v2;
    logic        _rs_full;

    logic        _cdb_ready;
    logic [4:0]  _cdb_rob_id;
    logic [31:0] _cdb_value;
    logic        _lsb_cdb_ready;
    logic [4:0]  _lsb_cdb_rob_id;
    logic [31:0] _lsb_cdb_value;

    logic        _alu_ready;
    logic [4:0]  _alu_rob_id;
    logic [6:0]  _alu_type;
    logic [3:0]  _alu_op;
    logic [31:0] _alu_v1;
    logic [31:0] _alu_v2;

    modport master (
        output _rs_ready, _rs_rob_id, _rs_type, _rs_op,
        output _rs_q1_ready, _rs_q2_ready, _rs_q1, _rs_q2, _rs_v1, _rs_v2,
        output _cdb_ready, _cdb_rob_id, _cdb_value,
        output _lsb_cdb_ready, _lsb_cdb_rob_id, _lsb_cdb_value,
        input  _rs_full,
        input  _alu_ready, _alu_rob_id, _alu_type, _alu_op, _alu_v1, _alu_v2
    );

    modport slave (
        input  _rs_ready, _rs_rob_id, _rs_type, _rs_op,
        input  _rs_q1_ready, _rs_q2_ready, _rs_q1, _rs_q2, _rs_v1, _rs_v2,
        input  _cdb_ready, _cdb_rob_id, _cdb_value,
        input  _lsb_cdb_ready, _lsb_cdb_rob_id, _lsb_cdb_value,
        output _rs_full,
        output _alu_ready, _alu_rob_id, _alu_type, _alu_op, _alu_v1, _alu_v2
    );
endinterface

// File: rtl/alu_rs.sv
// ALU reservation station: holds dispatched instructions until both operands
// arrive over either CDB, then issues the lowest-index ready entry to the ALU.
module alu_rs #(
    parameter int RS_SIZE = 8
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       rdy_in,
    input  logic       _clear,
    alu_rs_if.slave    bus
);
    localparam int IDX_W = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0] busy;
    logic [RS_SIZE-1:0] q1_rdy;
    logic [RS_SIZE-1:0] q2_rdy;
    logic [4:0]         rob_id [RS_SIZE];
    logic [6:0]         op_type [RS_SIZE];
    logic [3:0]         op [RS_SIZE];
    logic [4:0]         q1 [RS_SIZE];
    logic [4:0]         q2 [RS_SIZE];
    logic [31:0]        v1 [RS_SIZE];
    logic [31:0]        v2 [RS_SIZE];

    logic [4:0]         alu_rob_id;
    logic [6:0]         alu_type;
    logic [3:0]         alu_op;
    logic [31:0]        alu_v1;
    logic [31:0]        alu_v2;

    logic [IDX_W-1:0]   issue_idx;
    logic [IDX_W-1:0]   free_idx;
    logic               issue_found;
    logic               rs_full;
    logic               issue_fire;
    logic               dispatch_fire;
    logic               d1_rdy;
    logic               d2_rdy;
    logic [31:0]        d1_val;
    logic [31:0]        d2_val;

    // Both searches look only at registered state, so a slot freed by issue
    // this cycle cannot be handed to a dispatch in the same cycle.
    always_comb begin
        issue_found = 1'b0;
        issue_idx   = '0;
        free_idx    = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (busy[i] && q1_rdy[i] && q2_rdy[i]) begin
                issue_found = 1'b1;
                issue_idx   = IDX_W'(i);
            end
            if (!busy[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    assign rs_full       = &busy;
    assign issue_fire    = issue_found && rdy_in && !_clear && !rst_in;
    assign dispatch_fire = bus._rs_ready && rdy_in && !_clear && !rs_full;

    // Operands still missing at dispatch may be supplied by a broadcast in the
    // very same cycle; the ALU bus takes priority over the load-store bus.
    always_comb begin
        d1_rdy = bus._rs_q1_ready;
        d1_val = bus._rs_v1;
        d2_rdy = bus._rs_q2_ready;
        d2_val = bus._rs_v2;
        if (!bus._rs_q1_ready) begin
            if (bus._cdb_ready && bus._cdb_rob_id == bus._rs_q1) begin
                d1_rdy = 1'b1;
                d1_val = bus._cdb_value;
            end else if (bus._lsb_cdb_ready && bus._lsb_cdb_rob_id == bus._rs_q1) begin
                d1_rdy = 1'b1;
                d1_val = bus._lsb_cdb_value;
            end
        end
        if (!bus._rs_q2_ready) begin
            if (bus._cdb_ready && bus._cdb_rob_id == bus._rs_q2) begin
                d2_rdy = 1'b1;
                d2_val = bus._cdb_value;
            end else if (bus._lsb_cdb_ready && bus._lsb_cdb_rob_id == bus._rs_q2) begin
                d2_rdy = 1'b1;
                d2_val = bus._lsb_cdb_value;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy       <= '0;
            alu_rob_id <= '0;
            alu_type   <= '0;
            alu_op     <= '0;
            alu_v1     <= '0;
            alu_v2     <= '0;
        end else if (rdy_in) begin
            if (_clear) begin
                busy <= '0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (busy[i] && !q1_rdy[i]) begin
                        if (bus._cdb_ready && bus._cdb_rob_id == q1[i]) begin
                            q1_rdy[i] <= 1'b1;
                            v1[i]     <= bus._cdb_value;
                        end else if (bus._lsb_cdb_ready && bus._lsb_cdb_rob_id == q1[i]) begin
                            q1_rdy[i] <= 1'b1;
                            v1[i]     <= bus._lsb_cdb_value;
                        end
                    end
                    if (busy[i] && !q2_rdy[i]) begin
                        if (bus._cdb_ready && bus._cdb_rob_id == q2[i]) begin
                            q2_rdy[i] <= 1'b1;
                            v2[i]     <= bus._cdb_value;
                        end else if (bus._lsb_cdb_ready && bus._lsb_cdb_rob_id == q2[i]) begin
                            q2_rdy[i] <= 1'b1;
                            v2[i]     <= bus._lsb_cdb_value;
                        end
                    end
                end

                // The issue registers hold between issues so the ALU sees
                // stable operands during its result cycle.
                if (issue_fire) begin
                    alu_rob_id        <= rob_id[issue_idx];
                    alu_type          <= op_type[issue_idx];
                    alu_op            <= op[issue_idx];
                    alu_v1            <= v1[issue_idx];
                    alu_v2            <= v2[issue_idx];
                    busy[issue_idx]   <= 1'b0;
                end

                if (dispatch_fire) begin
                    busy[free_idx]    <= 1'b1;
                    rob_id[free_idx]  <= bus._rs_rob_id;
                    op_type[free_idx] <= bus._rs_type;
                    op[free_idx]      <= bus._rs_op;
                    q1[free_idx]      <= bus._rs_q1;
                    q2[free_idx]      <= bus._rs_q2;
                    q1_rdy[free_idx]  <= d1_rdy;
                    q2_rdy[free_idx]  <= d2_rdy;
                    v1[free_idx]      <= d1_val;
                    v2[free_idx]      <= d2_val;
                end
            end
        end
    end

    assign bus._rs_full     = rs_full;
    assign bus._alu_ready   = issue_fire;
    assign bus._alu_rob_id  = alu_rob_id;
    assign bus._alu_type    = alu_type;
    assign bus._alu_op      = alu_op;
    assign bus._alu_v1      = alu_v1;
    assign bus._alu_v2      = alu_v2;
endmodule
